// File: rtl/aoi22_bist_pkg.sv
// aoi22_bist_pkg: shared state type, vector sizing and golden model for the AOI22 BIST controller
package aoi22_bist_pkg;
    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
    localparam int VEC_W = 4;
    localparam int NUM_VEC = 16;
    function automatic logic aoi22_golden(input logic [VEC_W-1:0] vec);
        return ~((vec[3] & vec[2]) | (vec[1] & vec[0]));
    endfunction
endpackage

// File: rtl/aoi22_bist_ctrl.sv
// aoi22_bist_ctrl: drives all 16 AOI22 input vectors, waits a settle time per vector,
// checks the cell output against the golden model and reports pass/fail and first failure
module aoi22_bist_ctrl
    import aoi22_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             dut_f,
    output logic [VEC_W-1:0] drv_vec,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             first_fail_valid,
    output logic [VEC_W-1:0] first_fail_vec
);
    localparam int CW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(SETTLE_CYCLES - 1);
    generate
        if (SETTLE_CYCLES < 1) begin : g_bad_settle
            $error("SETTLE_CYCLES must be >= 1");
        end
    endgenerate
    state_t state;
    logic [VEC_W-1:0] vec;
    logic [CW-1:0] cnt;
    logic miss;
    // case inequality so a floating (X/Z) cell output is reported as a fault
    assign miss = dut_f !== aoi22_golden(vec);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            vec              <= '0;
            cnt              <= '0;
            drv_vec          <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
        end else begin
            done <= 1'b0;
            if (abort && (state == SETTLE || state == SAMPLE)) begin
                state   <= IDLE;
                drv_vec <= '0;
                busy    <= 1'b0;
                pass    <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (start && !abort) begin
                        state            <= SETTLE;
                        vec              <= '0;
                        cnt              <= '0;
                        drv_vec          <= '0;
                        busy             <= 1'b1;
                        pass             <= 1'b0;
                        err_count        <= '0;
                        first_fail_valid <= 1'b0;
                        first_fail_vec   <= '0;
                    end
                    SETTLE: begin
                        if (cnt == LAST) state <= SAMPLE;
                        else cnt <= cnt + CW'(1);
                    end
                    SAMPLE: begin
                        if (miss) begin
                            if (err_count != '1) err_count <= err_count + ERR_W'(1);
                            if (!first_fail_valid) begin
                                first_fail_valid <= 1'b1;
                                first_fail_vec   <= vec;
                            end
                        end
                        if (vec != VEC_W'(NUM_VEC - 1)) begin
                            vec     <= vec + VEC_W'(1);
                            drv_vec <= vec + VEC_W'(1);
                            cnt     <= '0;
                            state   <= SETTLE;
                        end else begin
                            state   <= DONE;
                            drv_vec <= '0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            pass    <= (err_count == '0) && !miss;
                        end
                    end
                    DONE: state <= IDLE;
                endcase
            end
        end
    end
endmodule
